// File: rtl/raymarch_frame_scheduler.sv
// Frame scheduler for the raymarcher: issues pixels against FIFO credit, re-tags the
// fixed-latency colour stream with frame-buffer addresses and drains it over valid/ready.
module raymarch_frame_scheduler #(
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int PIPE_LATENCY = 64,
   parameter int FIFO_DEPTH   = 128,
   parameter int ADDR_W       = 19
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   input  logic              cfg_wr,
   input  logic [3:0]        cfg_addr,
   input  logic [26:0]       cfg_data,
   output logic [9:0]        rm_pixel_x,
   output logic [9:0]        rm_pixel_y,
   output logic [242:0]      rm_look_at,
   output logic [80:0]       rm_eye,
   input  logic [7:0]        rm_red,
   input  logic [7:0]        rm_green,
   input  logic [7:0]        rm_blue,
   output logic              fb_valid,
   input  logic              fb_ready,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [23:0]       fb_data
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = ADDR_W + 24;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [9:0]        x_q, x_d, y_q, y_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [26:0]       staging_q [12];
   logic [26:0]       staging_d [12];
   logic [242:0]      look_at_q, look_at_d;
   logic [80:0]       eye_q, eye_d;
   logic [PIPE_LATENCY:0] tag_vld_q, tag_vld_d;
   logic [ADDR_W-1:0] tag_addr_q [PIPE_LATENCY+1];
   logic [ADDR_W-1:0] tag_addr_d [PIPE_LATENCY+1];
   logic [CW-1:0]     inflight_q, inflight_d, count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DW-1:0]     mem_q [FIFO_DEPTH];
   logic              busy_q, busy_d, done_q, done_d;
   logic              launch_s, push_s, pop_s, last_pix_s, credit_s;
   logic [CW:0]       outstanding_s;
   logic [DW-1:0]     head_s;

   // Credit covers both in-flight tags and queued results, so a push can never find the FIFO full.
   always_comb begin
      outstanding_s = {1'b0, inflight_q} + {1'b0, count_q};
      credit_s      = outstanding_s < (CW+1)'(FIFO_DEPTH);
      launch_s      = (state_q == S_ISSUE) && credit_s;
      push_s        = tag_vld_q[PIPE_LATENCY];
      pop_s         = (count_q != '0) && fb_ready;
      last_pix_s    = (x_q == 10'(SCREEN_W - 1)) && (y_q == 10'(SCREEN_H - 1));
      head_s        = mem_q[rd_ptr_q];
   end

   // Frame sequencing, pixel counters, config shadowing and status flags.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      addr_d    = addr_q;
      pix_x_d   = pix_x_q;
      pix_y_d   = pix_y_q;
      look_at_d = look_at_q;
      eye_d     = eye_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LOAD;
            else       state_d = S_IDLE;
         end
         S_LOAD: begin
            for (int i = 0; i < 9; i++) look_at_d[27*i +: 27] = staging_q[i];
            for (int j = 0; j < 3; j++) eye_d[27*j +: 27] = staging_q[9+j];
            x_d     = 10'd0;
            y_d     = 10'd0;
            addr_d  = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (launch_s) begin
               pix_x_d = x_q;
               pix_y_d = y_q;
               addr_d  = addr_q + ADDR_W'(1);
               if (x_q == 10'(SCREEN_W - 1)) begin
                  x_d = 10'd0;
                  y_d = y_q + 10'd1;
               end else begin
                  x_d = x_q + 10'd1;
               end
               if (last_pix_s) state_d = S_DRAIN;
               else            state_d = S_ISSUE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if ((inflight_q == '0) && (count_q == '0)) state_d = S_DONE;
            else                                       state_d = S_DRAIN;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_LOAD) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   // Staging writes, tag delay line and FIFO bookkeeping.
   always_comb begin
      staging_d = staging_q;
      if (cfg_wr && (cfg_addr < 4'd12)) staging_d[cfg_addr] = cfg_data;
      else                              staging_d = staging_q;
      tag_vld_d     = {tag_vld_q[PIPE_LATENCY-1:0], launch_s};
      tag_addr_d[0] = addr_q;
      for (int i = 1; i <= PIPE_LATENCY; i++) tag_addr_d[i] = tag_addr_q[i-1];
      case ({launch_s, push_s})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
   end

   // State and control registers; reset aborts the frame and invalidates every tag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         x_q        <= 10'd0;
         y_q        <= 10'd0;
         addr_q     <= '0;
         pix_x_q    <= 10'd0;
         pix_y_q    <= 10'd0;
         look_at_q  <= '0;
         eye_q      <= '0;
         tag_vld_q  <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 12; i++) staging_q[i] <= 27'd0;
         for (int i = 0; i <= PIPE_LATENCY; i++) tag_addr_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         addr_q     <= addr_d;
         pix_x_q    <= pix_x_d;
         pix_y_q    <= pix_y_d;
         look_at_q  <= look_at_d;
         eye_q      <= eye_d;
         tag_vld_q  <= tag_vld_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         staging_q  <= staging_d;
         tag_addr_q <= tag_addr_d;
      end
   end

   // Result storage; contents are only observable through the count-gated head.
   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q] <= {tag_addr_q[PIPE_LATENCY], rm_red, rm_green, rm_blue};
   end

   assign busy       = busy_q;
   assign frame_done = done_q;
   assign rm_pixel_x = pix_x_q;
   assign rm_pixel_y = pix_y_q;
   assign rm_look_at = look_at_q;
   assign rm_eye     = eye_q;
   assign fb_valid   = (count_q != '0);
   assign fb_addr    = fb_valid ? head_s[DW-1:24] : '0;
   assign fb_data    = fb_valid ? head_s[23:0]    : 24'd0;
endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Scoreboard bench: a 4x3 frame through a 5-cycle colour model, checking order, stall
// stability, credit limit, config shadowing, restart rejection and mid-frame reset.
module tb_raymarch_frame_scheduler;
   localparam int W = 4, H = 3, L = 5, D = 8, AW = 19;

   logic          clk = 1'b0;
   logic          reset_n, start, busy, frame_done, cfg_wr, fb_valid, fb_ready;
   logic [3:0]    cfg_addr;
   logic [26:0]   cfg_data;
   logic [9:0]    rm_pixel_x, rm_pixel_y;
   logic [242:0]  rm_look_at;
   logic [80:0]   rm_eye;
   logic [7:0]    rm_red, rm_green, rm_blue;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_data;

   int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0, last_pop_cyc = 0, lat = 0;
   logic [AW+23:0] exp_q [$];
   logic           prev_stall = 1'b0;
   logic [AW-1:0]  prev_addr;
   logic [23:0]    prev_data;
   logic [23:0]    cpipe [L];

   raymarch_frame_scheduler #(.SCREEN_W(W), .SCREEN_H(H), .PIPE_LATENCY(L),
                              .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .frame_done(frame_done),
      .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .rm_pixel_x(rm_pixel_x), .rm_pixel_y(rm_pixel_y), .rm_look_at(rm_look_at),
      .rm_eye(rm_eye), .rm_red(rm_red), .rm_green(rm_green), .rm_blue(rm_blue),
      .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data));

   always #5 clk = ~clk;

   // Raymarcher stand-in: colour {x,y,x^y} appears exactly L cycles after the pixel.
   always @(posedge clk) begin
      cpipe[0] <= {rm_pixel_x[7:0], rm_pixel_y[7:0], rm_pixel_x[7:0] ^ rm_pixel_y[7:0]};
      for (int i = 1; i < L; i++) cpipe[i] <= cpipe[i-1];
   end
   assign {rm_red, rm_green, rm_blue} = cpipe[L-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_frame();
      for (int a = 0; a < W*H; a++) begin
         logic [7:0] x, y;
         x = 8'(a % W);
         y = 8'(a / W);
         exp_q.push_back({AW'(a), x, y, x ^ y});
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [26:0] d);
      cfg_wr = 1'b1; cfg_addr = a; cfg_data = d;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 300; i++) begin
         if (done_cnt >= target) break;
         @(negedge clk);
      end
      chk("frame_done_seen", 64'(done_cnt >= target), 64'd1);
   endtask

   // Monitor: pops the scoreboard on each accepted word, checks hold-while-stalled and done timing.
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 64'(fb_valid), 64'd1);
            chk("stall_addr", 64'(fb_addr), 64'(prev_addr));
            chk("stall_data", 64'(fb_data), 64'(prev_data));
         end
         if (fb_valid && fb_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL pop_unexpected: got addr %0h expected no output", fb_addr);
            end else begin
               logic [AW+23:0] e;
               e = exp_q.pop_front();
               chk("fb_addr", 64'(fb_addr), 64'(e[AW+23:24]));
               chk("fb_data", 64'(fb_data), 64'(e[23:0]));
               if (exp_q.size() == 0) last_pop_cyc = cyc;
            end
         end
         prev_stall = fb_valid && !fb_ready;
         prev_addr  = fb_addr;
         prev_data  = fb_data;
         if (frame_done) begin
            done_cnt++;
            chk("done_after_last_pop", 64'(cyc - last_pop_cyc), 64'd2);
            chk("busy_at_done", 64'(busy), 64'd0);
         end
      end
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; cfg_wr = 1'b0; cfg_addr = 4'd0; cfg_data = 27'd0;
      fb_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(frame_done), 64'd0);
      chk("rst_fb_valid", 64'(fb_valid), 64'd0);
      chk("rst_fb_addr", 64'(fb_addr), 64'd0);
      chk("rst_fb_data", 64'(fb_data), 64'd0);
      chk("rst_pixel", 64'({rm_pixel_x, rm_pixel_y}), 64'd0);
      chk("rst_shadow", 64'(|{rm_look_at, rm_eye}), 64'd0);

      // Frame A: free-flowing writer, config staged beforehand, disturbed mid-frame.
      cfg_write(4'd9, 27'h1fc0000);
      cfg_write(4'd0, 27'h0000123);
      cfg_write(4'd13, 27'h5555555);
      push_frame();
      pulse_start();
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (fb_valid) begin lat = k; break; end
      end
      chk("first_valid_latency", 64'(lat), 64'd8);
      chk("eye_x_loaded", 64'(rm_eye[26:0]), 64'h1fc0000);
      chk("eye_yz_zero", 64'(|rm_eye[80:27]), 64'd0);
      chk("look_11_loaded", 64'(rm_look_at[26:0]), 64'h0000123);
      chk("look_rest_zero", 64'(|rm_look_at[242:27]), 64'd0);
      chk("busy_mid_frame", 64'(busy), 64'd1);
      cfg_wr = 1'b1; cfg_addr = 4'd9; cfg_data = 27'h0abcdef; start = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0; start = 1'b0;
      wait_done(1);
      repeat (10) @(negedge clk);
      chk("single_done_a", 64'(done_cnt), 64'd1);
      chk("queue_empty_a", 64'(exp_q.size()), 64'd0);
      chk("eye_held_a", 64'(rm_eye[26:0]), 64'h1fc0000);

      // Frame B: writer stalled for 40 cycles, credit must cap launches at 8 pixels.
      fb_ready = 1'b0;
      push_frame();
      pulse_start();
      repeat (40) @(negedge clk);
      chk("eye_reloaded", 64'(rm_eye[26:0]), 64'h0abcdef);
      chk("credit_pixel_x", 64'(rm_pixel_x), 64'd3);
      chk("credit_pixel_y", 64'(rm_pixel_y), 64'd1);
      chk("stall_head_valid", 64'(fb_valid), 64'd1);
      chk("stall_head_addr", 64'(fb_addr), 64'd0);
      fb_ready = 1'b1;
      wait_done(2);
      repeat (5) @(negedge clk);
      chk("queue_empty_b", 64'(exp_q.size()), 64'd0);

      // Frame C: aborted by reset during issue.
      push_frame();
      pulse_start();
      repeat (9) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_busy", 64'(busy), 64'd0);
      chk("async_fb_valid", 64'(fb_valid), 64'd0);
      chk("async_fb_addr", 64'(fb_addr), 64'd0);
      chk("async_pixel", 64'({rm_pixel_x, rm_pixel_y}), 64'd0);
      chk("async_shadow", 64'(|{rm_look_at, rm_eye}), 64'd0);
      @(negedge clk);
      exp_q.delete();
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_empty", 64'(fb_valid), 64'd0);
      chk("no_done_aborted", 64'(done_cnt), 64'd2);

      // Frame D: clean frame after reset; staging was cleared and cfg_addr 13 is ignored.
      cfg_write(4'd13, 27'h7ffffff);
      push_frame();
      pulse_start();
      repeat (3) @(negedge clk);
      chk("eye_cleared", 64'(|rm_eye), 64'd0);
      chk("look_cleared", 64'(|rm_look_at), 64'd0);
      wait_done(3);
      repeat (5) @(negedge clk);
      chk("queue_empty_d", 64'(exp_q.size()), 64'd0);
      chk("done_total", 64'(done_cnt), 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end
endmodule

// File: doc/raymarch_frame_scheduler.md
Name: raymarch_frame_scheduler

Overview:
- Sequences one full frame of pixel coordinates into the free-running raymarcher pipeline, one pixel per cycle while credit is available.
- The pipeline has fixed latency and no stall. A matched tag delay line therefore re-associates each returned colour with its frame-buffer address.
- Results are buffered in a FIFO and drained to the frame-buffer writer over a valid/ready handshake.
- Also holds the HPS camera configuration (look-at matrix, eye), shadowed at frame start so mid-frame HPS writes never tear an image.

Parameters:
- SCREEN_W, 640, pixels per line.
- SCREEN_H, 480, lines per frame.
- PIPE_LATENCY, 64, cycles from pixel_x/pixel_y presented to red/green/blue valid; must equal raymarcher latency; >=1.
- FIFO_DEPTH, 128, result FIFO entries; power of two; full throughput requires FIFO_DEPTH >= PIPE_LATENCY+2.
- ADDR_W, 19, frame-buffer address width; 2^ADDR_W >= SCREEN_W*SCREEN_H.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a frame (ignored unless idle)
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is accepted by the writer
- cfg_wr  in  1  write strobe for staging config registers
- cfg_addr  in  4  0-8 = look_at_1_1..look_at_3_3 row-major, 9-11 = eye_x/y/z, 12-15 ignored
- cfg_data  in  27  custom 27-bit float
- rm_pixel_x  out  10  pixel x to raymarcher
- rm_pixel_y  out  10  pixel y to raymarcher
- rm_look_at  out  243  shadow matrix, element 1_1 in bits [26:0] ascending to 3_3
- rm_eye  out  81  shadow eye, x in [26:0], y [53:27], z [80:54]
- rm_red, rm_green, rm_blue  in  8 each  raymarcher colour outputs
- fb_valid  out  1  FIFO head valid
- fb_ready  in  1  writer accepts head
- fb_addr  out  ADDR_W  y*SCREEN_W+x of head
- fb_data  out  24  {red,green,blue} of head

Behaviour:
- Reset values: all outputs 0; staging and shadow registers 0; FIFO empty; tag line invalid; state IDLE.
- cfg_wr: writes staging[cfg_addr] on the clock edge, in any state. Shadow (rm_look_at/rm_eye) updates only in LOAD.
- FSM:
  - IDLE: start -> LOAD.
  - LOAD (1 cycle): shadow <= staging; x, y, addr counters <= 0; busy=1; -> ISSUE.
  - ISSUE: each cycle with credit, launch pixel (x,y). Last pixel launched -> DRAIN.
  - DRAIN: wait until tag line and FIFO are empty -> DONE.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Launch: rm_pixel_x/y are registered. The cycle they change is launch cycle t. A tag {valid=1, addr} enters the delay line at t and exits at t+PIPE_LATENCY, when rm_red/green/blue are sampled into the FIFO. No launch = bubble tag (valid=0); rm_pixel_x/y hold their last value.
- Counters: x increments to SCREEN_W-1 then wraps to 0 with y+1. addr increments by 1 (no multiplier). Last pixel = (SCREEN_W-1, SCREEN_H-1).
- Credit: launch allowed iff inflight + fifo_count + (push this cycle ? 0 : 0) < FIFO_DEPTH, where inflight = valid tags in the line.
  - Guarantees a push never meets a full FIFO; overflow is impossible by construction.
  - Simultaneous pop and launch is permitted in the same cycle.
- FIFO: first-word fall-through. fb_valid = !empty. A pop occurs on fb_valid && fb_ready. fb_addr/fb_data must stay stable while fb_valid && !fb_ready. Simultaneous push and pop keeps the count unchanged.
- start while busy: ignored; no restart.
- cfg_wr in the same cycle as LOAD: LOAD copies the pre-write staging value.
- Reset mid-frame: immediate abort. Everything returns to reset values, and in-flight raymarcher results are discarded (tags invalid).
- Ordering: fb_addr must be strictly increasing 0..SCREEN_W*SCREEN_H-1 within a frame, with no gaps or duplicates.

Test Plan:
- SCREEN_W=4, SCREEN_H=3, PIPE_LATENCY=5, FIFO_DEPTH=8, fb_ready=1; colour model = {x,y,x^y} delayed 5 -> 12 writes, addr 0..11 with matching data; first fb_valid at launch+5; frame_done 1 cycle after the 12th pop; busy falls with it.
- Same config, fb_ready=0 for 40 cycles then 1 -> at most 8 launches outstanding, fb_addr/fb_data held stable while stalled, no loss or duplication; all 12 delivered in order.
- Random fb_ready (50%) over a 640x480 frame with PIPE_LATENCY=64 -> 307200 writes, addresses strictly sequential, FIFO count never exceeds 128.
- cfg_wr addr 9 = 27'h1fc0000 while busy -> rm_eye unchanged until next start; after LOAD rm_eye[26:0]=27'h1fc0000. cfg_addr 13 write -> no register changes.
- start pulsed again mid-frame -> ignored, single frame_done.
- reset_n low for 1 cycle mid-ISSUE -> outputs 0 asynchronously, FIFO empty; next start produces a clean frame from addr 0.
